fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
Read-side consumer for the dual-clock FIFO; runs entirely in the FIFO read clock domain. Pops DW-bit entries from the FIFO's read port and packs RATIO consecutive entries into one DW*RATIO-bit word. Presents the packed word on a valid/ready stream. A flush input forces out a partially filled word, with a byte-lane keep mask.

Parameters:
DW, 8, FIFO entry width in bits.
RATIO, 4, FIFO entries per output word; power of two, 2..16.
CW, $clog2(RATIO+1), width of lane counter.

Ports:
clk  in  1  read-domain clock (same clock as the FIFO r_clk).
rst  in  1  reset; asynchronous, active-high (same net as the FIFO r_rst).
fifo_empty  in  1  FIFO r_empty.
fifo_read  out  1  pop strobe to the FIFO read input.
fifo_dout  in  DW  FIFO dout; valid exactly 1 cycle after a fifo_read cycle.
flush  in  1  level request: emit any partial word.
out_data  out  DW*RATIO  packed word; entry k in bits [k*DW +: DW].
out_keep  out  RATIO  bit k = lane k holds data.
out_valid  out  1  out_data/out_keep valid.
out_ready  in  1  downstream accept.
busy  out  1  cnt!=0 or rd_q or out_valid.

Behaviour:
- Reset: all registers clear asynchronously. out_valid=0, out_data=0, out_keep=0, fifo_read=0, busy=0, cnt=0, rd_q=0, flush_pend=0.
- rd_q is fifo_read registered. When rd_q=1, fifo_dout is captured into assembly lane cnt_eff; cnt_eff then increments.
- Lane fill order: the first entry popped goes to lane 0 (LSBs). Lanes not filled read as zero.
- xfer is asserted when (cnt==RATIO, or flush_pend && cnt!=0 && !rd_q) and (!out_valid || out_ready).
  - On xfer: the assembly moves into the output register, out_keep = (1<<cnt)-1, out_valid=1 next cycle.
  - cnt_eff = xfer ? 0 : cnt.
- A byte captured in the same cycle as xfer lands in lane 0 of the new assembly. No data is lost or duplicated.
- out_valid && out_ready && !xfer: out_valid drops to 0 next cycle.
- fifo_read = !fifo_empty && !flush_pend && (cnt_eff + rd_q < RATIO).
  - Combinational on out_ready via xfer; this path is accepted.
  - fifo_read is never asserted while fifo_empty=1.
- Sustained rate: RATIO entries per RATIO+1 cycles when the FIFO stays non-empty and out_ready=1. The one bubble per word is by design.
- Backpressure: with out_valid=1 and out_ready=0, the assembly fills to RATIO, then reads stop. The FIFO keeps its data; nothing is dropped.
- Flush handling:
  - flush=1 sets flush_pend and blocks new reads. An in-flight rd_q byte is still captured.
  - flush_pend clears on the flush xfer, or immediately if cnt==0 && !rd_q.
  - A flush with an empty assembly produces no word.
  - If cnt reaches RATIO during a flush, a normal full word is emitted with out_keep all ones.
- out_data, out_keep, out_valid are stable while out_valid && !out_ready.
- Reset asserted mid-word: the partial assembly is discarded and outputs go to 0 at once. Any entry already popped from the FIFO is lost; the FIFO is reset on the same net.

Decomposition:
- Package fifo_rd_pkg holds:
  - the lane-index helper function;
  - keep-mask function mask(cnt) = (1<<cnt)-1;
  - default DW/RATIO localparams shared with benches.
- No sub-module: assembly register, counter and output register are all in one module.

Test Plan:
Use DW=8, RATIO=4, DcFifo AW=3 upstream.
1. Write 8 bytes 0x11..0x88, out_ready=1 -> two words, 0x44332211 then 0x88776655, out_keep=4'hF. fifo_read never asserted with fifo_empty=1.
2. Write 6 bytes 0x01..0x06, then pulse flush after the FIFO drains -> 0x04030201 keep F, then 0x00000605 keep 4'h3. busy=0 afterwards.
3. Hold out_ready=0, write 8 bytes -> first word held stable, assembly stops at cnt=4, FIFO keeps 0 entries in flight. Release out_ready -> both words in order, no loss.
4. Flush with the FIFO and assembly empty -> out_valid stays 0, flush_pend clears in 1 cycle.
5. Continuous writes of 16 bytes with out_ready=1 -> 4 words in order, spacing 5 cycles each.
6. Assert rst after 2 bytes captured -> outputs 0 immediately. After release, writing 0xA1..0xA4 gives 0xA4A3A2A1 keep F.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the FIFO read-side packer.
// Default widths are also used by benches so both sides agree on geometry.
package fifo_rd_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_RATIO = 4;
  localparam int MAX_RATIO = 16;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

  // Contiguous low-lane mask: n lanes filled -> n ones from bit 0 upward.
  function automatic logic [MAX_RATIO-1:0] mask(input int unsigned n);
    logic [MAX_RATIO-1:0] m;
    for (int unsigned k = 0; k < MAX_RATIO; k++) begin
      m[k] = (k < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops DW-bit FIFO entries and packs RATIO of them into one valid/ready word;
// a flush request emits a partially filled word with a lane keep mask.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int RATIO = DEF_RATIO,
  parameter int CW    = $clog2(RATIO + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty,
  output logic                fifo_read,
  input  logic [DW-1:0]       fifo_dout,
  input  logic                flush,
  output logic [DW*RATIO-1:0] out_data,
  output logic [RATIO-1:0]    out_keep,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  logic [CW-1:0]       r_cnt;
  logic                r_rd_q;
  logic                r_flush_pend;
  logic [DW*RATIO-1:0] r_asm;
  logic [DW*RATIO-1:0] r_out_data;
  logic [RATIO-1:0]    r_out_keep;
  logic                r_out_valid;

  logic                w_full;
  logic                w_cnt_nz;
  logic                w_out_free;
  logic                w_flush_go;
  logic                w_xfer;
  logic [CW-1:0]       w_cnt_eff;
  logic                w_room;
  logic                w_fifo_read;
  logic                w_flush_clr;
  logic [DW*RATIO-1:0] w_asm_next;

  assign w_full     = (r_cnt == CW'(RATIO));
  assign w_cnt_nz   = (r_cnt != '0);
  assign w_out_free = !r_out_valid || out_ready;
  // A flush may only close the word once no popped entry is still in flight.
  assign w_flush_go = r_flush_pend && w_cnt_nz && !r_rd_q;
  assign w_xfer     = (w_full || w_flush_go) && w_out_free;
  assign w_cnt_eff  = w_xfer ? '0 : r_cnt;

  // Equivalent to cnt_eff + rd_q < RATIO without widening the counter.
  assign w_room      = r_rd_q ? (w_cnt_eff < CW'(RATIO - 1)) : (w_cnt_eff < CW'(RATIO));
  assign w_fifo_read = !fifo_empty && !r_flush_pend && w_room;
  assign w_flush_clr = w_xfer || (!w_cnt_nz && !r_rd_q);

  // A word leaving the assembly restarts it from zero so unfilled lanes read 0.
  always_comb begin
    w_asm_next = w_xfer ? '0 : r_asm;
    for (int k = 0; k < RATIO; k++) begin
      if (r_rd_q && (w_cnt_eff == CW'(k))) begin
        w_asm_next[lane_lo(k, DW) +: DW] = fifo_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_rd_q       <= 1'b0;
      r_flush_pend <= 1'b0;
      r_asm        <= '0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_rd_q       <= w_fifo_read;
      r_cnt        <= w_cnt_eff + CW'(r_rd_q);
      r_asm        <= w_asm_next;
      r_flush_pend <= flush || (r_flush_pend && !w_flush_clr);
      if (w_xfer) begin
        r_out_data  <= r_asm;
        r_out_keep  <= RATIO'(mask(int'(r_cnt)));
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign fifo_read = w_fifo_read;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_valid = r_out_valid;
  assign busy      = w_cnt_nz || r_rd_q || r_out_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO read port feeds the DUT and a
// byte-list reference model predicts every packed word and keep mask.
module tb_fifo_rd_packer;
  import fifo_rd_pkg::*;

  localparam int DW    = DEF_DW;
  localparam int RATIO = DEF_RATIO;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                fifo_empty = 1'b1;
  logic                fifo_read;
  logic [DW-1:0]       fifo_dout = '0;
  logic                flush = 1'b0;
  logic [DW*RATIO-1:0] out_data;
  logic [RATIO-1:0]    out_keep;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                busy;

  fifo_rd_packer #(.DW(DW), .RATIO(RATIO)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_dout(fifo_dout), .flush(flush), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: bytes popped in order, grouped RATIO at a time.
  logic [DW-1:0]       fq[$];
  logic [DW-1:0]       pend[$];
  logic [DW*RATIO-1:0] exp_d[$];
  logic [RATIO-1:0]    exp_k[$];

  task automatic model_emit();
    logic [DW*RATIO-1:0] w;
    int n;
    w = '0;
    n = pend.size();
    for (int i = 0; i < n; i++) w = w | ((DW*RATIO)'(pend[i]) << (DW * i));
    exp_d.push_back(w);
    exp_k.push_back(RATIO'((1 << n) - 1));
    pend.delete();
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
    pend.push_back(b);
    if (pend.size() == RATIO) model_emit();
  endtask

  // Monitor: scoreboard on accept, stability while stalled.
  int                  cyc = 0;
  int                  acc_cyc[$];
  logic                hold = 1'b0;
  logic [DW*RATIO-1:0] hold_d = '0;
  logic [RATIO-1:0]    hold_k = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_data", 64'(out_data), 64'(hold_d));
        check_eq("hold_keep", 64'(out_keep), 64'(hold_k));
      end
      if (fifo_read) check_eq("rd_while_empty", 64'(fifo_empty), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          check_eq("extra_word", 64'(out_valid), 64'd0);
        end else begin
          check_eq("word_data", 64'(out_data), 64'(exp_d.pop_front()));
          check_eq("word_keep", 64'(out_keep), 64'(exp_k.pop_front()));
          acc_cyc.push_back(cyc);
        end
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      hold_k = out_keep;
    end
  end

  // Single stimulus process: FIFO read port emulation plus ready/flush drive.
  logic rnd_ready = 1'b0;

  task automatic tick(input int n);
    logic rd;
    repeat (n) begin
      @(negedge clk);
      rd = fifo_read;
      @(posedge clk);
      #1;
      if (rd && !rst && fq.size() != 0) fifo_dout = fq.pop_front();
      else                              fifo_dout = DW'($urandom);
      fifo_empty = (fq.size() == 0);
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int c;
    c = 0;
    while ((exp_d.size() != 0 || fq.size() != 0) && c < maxc) begin
      tick(1);
      c++;
    end
    check_eq({tag, "_drained"}, 64'(exp_d.size() + fq.size()), 64'd0);
    tick(3);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    if (pend.size() != 0) model_emit();
  endtask

  initial begin
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data", 64'(out_data), 64'd0);
    check_eq("rst_keep", 64'(out_keep), 64'd0);
    check_eq("rst_read", 64'(fifo_read), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Two full words at full rate.
    for (int i = 1; i <= 8; i++) push_byte(DW'(i * 8'h11));
    wait_drain("t1", 100);

    // Partial word via flush after the FIFO drains.
    for (int i = 1; i <= 6; i++) push_byte(DW'(i));
    wait_drain("t2", 100);
    do_flush();
    wait_drain("t2f", 100);
    check_eq("t2_busy", 64'(busy), 64'd0);

    // Backpressure: output held, assembly fills, FIFO left intact.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(DW'(i * 8'h11));
    tick(20);
    check_eq("t3_valid", 64'(out_valid), 64'd1);
    check_eq("t3_data", 64'(out_data), 64'h44332211);
    check_eq("t3_cnt", 64'(dut.r_cnt), 64'd4);
    check_eq("t3_read", 64'(fifo_read), 64'd0);
    check_eq("t3_fifo_left", 64'(fq.size()), 64'd0);
    out_ready = 1'b1;
    wait_drain("t3", 100);

    // Flush with nothing assembled.
    do_flush();
    tick(1);
    check_eq("t4_pend", 64'(dut.r_flush_pend), 64'd0);
    tick(3);
    check_eq("t4_valid", 64'(out_valid), 64'd0);
    check_eq("t4_busy", 64'(busy), 64'd0);

    // Sustained rate: one word every RATIO+1 cycles.
    acc_cyc.delete();
    for (int i = 0; i < 16; i++) push_byte(DW'($urandom));
    wait_drain("t5", 200);
    check_eq("t5_words", 64'(acc_cyc.size()), 64'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check_eq("t5_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(RATIO + 1));

    // Random lengths and random backpressure, closed by a flush.
    for (int r = 0; r < 6; r++) begin
      rnd_ready = 1'b1;
      for (int i = 0; i < int'($urandom_range(1, 13)); i++) push_byte(DW'($urandom));
      wait_drain("rnd", 400);
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      tick(2);
      do_flush();
      wait_drain("rndf", 100);
      check_eq("rnd_busy", 64'(busy), 64'd0);
    end

    // Reset mid-word discards everything at once.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fq.push_back(DW'(8'hB0 + i));
      fifo_empty = 1'b0;
    end
    tick(12);
    check_eq("t6_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_valid", 64'(out_valid), 64'd0);
    check_eq("t6_data", 64'(out_data), 64'd0);
    check_eq("t6_keep", 64'(out_keep), 64'd0);
    check_eq("t6_read", 64'(fifo_read), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    fq.delete();
    pend.delete();
    exp_d.delete();
    exp_k.delete();
    fifo_empty = 1'b1;
    out_ready  = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int i = 1; i <= 4; i++) push_byte(DW'(8'hA0 + i));
    wait_drain("t6", 100);
    check_eq("t6_busy_end", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
